// File: rtl/ir_packet_sequencer.sv
// ir_packet_sequencer: turns the latched 4-bit IR command into one modulated
// packet per accepted SEND. The packet is a start burst, a car-select burst and
// four direction bursts. Every burst is followed by a silent gap. IR_LED carries
// the carrier, gated by whether the current state is a burst state.
module ir_packet_sequencer #(
  parameter int CARRIER_HALF   = 1389,
  parameter int START_BURST    = 88,
  parameter int CAR_BURST      = 22,
  parameter int GAP_LEN        = 40,
  parameter int ASSERT_BURST   = 44,
  parameter int DEASSERT_BURST = 22
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SEND,
  input  logic [3:0] COMMAND,
  output logic       BUSY,
  output logic       IR_LED
);

  // Carrier phase spans one full carrier period: 0 .. 2*CARRIER_HALF-1.
  localparam int PHASE_MAX = 2 * CARRIER_HALF;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  // The period counter only has to reach (longest segment - 1).
  localparam int MAX_SC  = (START_BURST > CAR_BURST) ? START_BURST : CAR_BURST;
  localparam int MAX_AD  = (ASSERT_BURST > DEASSERT_BURST) ? ASSERT_BURST : DEASSERT_BURST;
  localparam int MAX_SCA = (MAX_SC > MAX_AD) ? MAX_SC : MAX_AD;
  localparam int MAX_LEN = (MAX_SCA > GAP_LEN) ? MAX_SCA : GAP_LEN;
  localparam int PER_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_MAX - 1);
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(CARRIER_HALF);

  localparam logic [PER_W-1:0] START_M1    = PER_W'(START_BURST - 1);
  localparam logic [PER_W-1:0] CAR_M1      = PER_W'(CAR_BURST - 1);
  localparam logic [PER_W-1:0] GAP_M1      = PER_W'(GAP_LEN - 1);
  localparam logic [PER_W-1:0] ASSERT_M1   = PER_W'(ASSERT_BURST - 1);
  localparam logic [PER_W-1:0] DEASSERT_M1 = PER_W'(DEASSERT_BURST - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_G0, S_CAR, S_G1, S_RIGHT, S_G2,
    S_LEFT, S_G3, S_BACK, S_G4, S_FWD, S_G5
  } state_t;

  state_t               state_reg, state_next;
  logic [PHASE_W-1:0]   phase_reg, phase_next;
  logic [PER_W-1:0]     period_reg, period_next;
  logic [3:0]           cmd_reg, cmd_next;
  logic                 ir_led_reg, ir_led_next;

  logic [PER_W-1:0]     dir_len_m1 [4];
  logic [PER_W-1:0]     len_m1;
  logic                 is_burst;
  logic                 carrier_high;
  logic                 phase_wrap;
  state_t               state_succ;

  // Direction burst length per latched command bit (right, left, back, fwd).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir_len
      assign dir_len_m1[gi] = cmd_reg[gi] ? ASSERT_M1 : DEASSERT_M1;
    end
  endgenerate

  // Decode the current state's length, burst flag and successor state.
  always_comb begin
    len_m1     = GAP_M1;
    is_burst   = 1'b0;
    state_succ = S_IDLE;
    case (state_reg)
      S_START: begin len_m1 = START_M1;      is_burst = 1'b1; state_succ = S_G0;    end
      S_G0:    begin                                          state_succ = S_CAR;   end
      S_CAR:   begin len_m1 = CAR_M1;        is_burst = 1'b1; state_succ = S_G1;    end
      S_G1:    begin                                          state_succ = S_RIGHT; end
      S_RIGHT: begin len_m1 = dir_len_m1[0]; is_burst = 1'b1; state_succ = S_G2;    end
      S_G2:    begin                                          state_succ = S_LEFT;  end
      S_LEFT:  begin len_m1 = dir_len_m1[1]; is_burst = 1'b1; state_succ = S_G3;    end
      S_G3:    begin                                          state_succ = S_BACK;  end
      S_BACK:  begin len_m1 = dir_len_m1[2]; is_burst = 1'b1; state_succ = S_G4;    end
      S_G4:    begin                                          state_succ = S_FWD;   end
      S_FWD:   begin len_m1 = dir_len_m1[3]; is_burst = 1'b1; state_succ = S_G5;    end
      default: begin                                          state_succ = S_IDLE;  end
    endcase
  end

  assign carrier_high = (phase_reg < PHASE_HIGH);
  assign phase_wrap   = (phase_reg == PHASE_LAST);

  // Next-state logic: accept SEND only in IDLE. Otherwise run the carrier and
  // advance on the carrier wrap that closes the state's last period.
  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    period_next = period_reg;
    cmd_next    = cmd_reg;
    ir_led_next = 1'b0;
    if (state_reg == S_IDLE) begin
      if (SEND) begin
        state_next  = S_START;
        cmd_next    = COMMAND;
        phase_next  = '0;
        period_next = '0;
      end
    end else begin
      ir_led_next = is_burst & carrier_high;
      phase_next  = phase_wrap ? '0 : phase_reg + 1'b1;
      if (phase_wrap) begin
        if (period_reg == len_m1) begin
          period_next = '0;
          state_next  = state_succ;
        end else begin
          period_next = period_reg + 1'b1;
        end
      end
    end
  end

  // State, counters, latched command and the registered LED output.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg  <= S_IDLE;
      phase_reg  <= '0;
      period_reg <= '0;
      cmd_reg    <= '0;
      ir_led_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      period_reg <= period_next;
      cmd_reg    <= cmd_next;
      ir_led_reg <= ir_led_next;
    end
  end

  assign BUSY   = (state_reg != S_IDLE);
  assign IR_LED = ir_led_reg;

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// Testbench for ir_packet_sequencer. A stimulus process drives SEND/COMMAND and
// queues an expected packet for each SEND that the sequencer should accept. A
// monitor process checks every packet it sees against a model of the packet.
module tb_ir_packet_sequencer;

  localparam int CH = 2;
  localparam int SB = 4;
  localparam int CB = 2;
  localparam int GL = 1;
  localparam int AB = 3;
  localparam int DB = 1;

  logic       CLK     = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SEND    = 1'b0;
  logic [3:0] COMMAND = 4'b0000;
  logic       BUSY;
  logic       IR_LED;

  ir_packet_sequencer #(
    .CARRIER_HALF(CH), .START_BURST(SB), .CAR_BURST(CB), .GAP_LEN(GL),
    .ASSERT_BURST(AB), .DEASSERT_BURST(DB)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SEND(SEND), .COMMAND(COMMAND),
    .BUSY(BUSY), .IR_LED(IR_LED)
  );

  always #5 CLK = ~CLK;

  // Index of the most recent rising clock edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] cmd;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_mode = 0;   // 0 idle, 1 checking a packet, 2 unexpected packet
  int   acc_edge = 0;
  int   end_edge = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Segment i of a packet: even i are bursts, odd i are gaps.
  function automatic int seg_len(logic [3:0] c, int i);
    if (i % 2 == 1) return GL;
    if (i == 0) return SB;
    if (i == 2) return CB;
    return c[(i - 4) / 2] ? AB : DB;
  endfunction

  function automatic int pkt_len(logic [3:0] c);
    int s = 0;
    for (int i = 0; i < 12; i++) s += seg_len(c, i);
    return s * 2 * CH;
  endfunction

  // Carrier-gated level k cycles into the packet.
  function automatic logic ref_led(logic [3:0] c, int k);
    int s = 0;
    for (int i = 0; i < 12; i++) begin
      int span = seg_len(c, i) * 2 * CH;
      if (k < s + span) return (i % 2 == 0) && (((k - s) % (2 * CH)) < CH);
      s += span;
    end
    return 1'b0;
  endfunction

  // One cycle of stimulus, applied at the falling edge for the next rising edge.
  task automatic drive_cycle(logic s, logic [3:0] c);
    int e;
    @(negedge CLK);
    check("busy_level", 32'(BUSY), 32'(cyc >= acc_edge && cyc < end_edge));
    SEND    = s;
    COMMAND = c;
    e = cyc + 1;
    if (s && e > end_edge) begin
      acc_edge = e;
      end_edge = e + pkt_len(c);
      exp_q.push_back('{c, pkt_len(c)});
    end
  endtask

  task automatic send_on_edge(int target, logic [3:0] c);
    while (cyc + 2 < target) drive_cycle(1'b0, c);
    drive_cycle(1'b1, c);
  endtask

  task automatic wait_idle(logic [3:0] c);
    while (cyc < end_edge + 1) drive_cycle(1'b0, c);
  endtask

  // Monitor: checks the LED waveform, pulse widths, burst grouping and BUSY length.
  initial begin
    exp_t cur;
    int   k, mism, hi, lo, grp, werr;
    logic prev, exp_led;
    int   groups[$];
    cur = '{4'b0000, 0};
    k = 0; mism = 0; hi = 0; lo = 0; grp = 0; werr = 0; prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        mon_mode = 0;
        continue;
      end
      if (mon_mode == 2 && !BUSY) mon_mode = 0;
      if (mon_mode == 0 && BUSY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_packet", 32'd1, 32'd0);
          mon_mode = 2;
        end else begin
          cur = exp_q.pop_front();
          mon_mode = 1;
          k = 0; mism = 0; hi = 0; lo = 1000; grp = 0; werr = 0; prev = 1'b0;
          groups.delete();
        end
      end
      if (mon_mode == 1) begin
        exp_led = (k == 0) ? 1'b0 : ref_led(cur.cmd, k - 1);
        if (IR_LED !== exp_led) mism++;
        if (IR_LED === 1'b1) begin
          if (!prev) begin
            if (lo > CH && grp > 0) begin
              groups.push_back(grp);
              grp = 0;
            end
            grp++;
            hi = 0;
          end
          hi++;
          lo = 0;
          prev = 1'b1;
        end else begin
          if (prev && hi != CH) werr++;
          lo++;
          prev = 1'b0;
        end
        if (!BUSY) begin
          if (grp > 0) groups.push_back(grp);
          check("busy_cycles", 32'(k), 32'(cur.len));
          check("led_wave_mismatches", 32'(mism), 32'd0);
          check("pulse_width_errors", 32'(werr), 32'd0);
          check("group_count", 32'(groups.size()), 32'd6);
          for (int g = 0; g < 6 && g < groups.size(); g++)
            check($sformatf("group%0d_pulses", g), 32'(groups[g]), 32'(seg_len(cur.cmd, 2 * g)));
          $display("PKT cmd=%b busy_cycles=%0d groups=%p", cur.cmd, k, groups);
          mon_mode = 0;
        end else begin
          k++;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int  e0;
    logic found;
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_led", 32'(IR_LED), 32'd0);
    RESET_N = 1'b1;

    // Single packets with complementary direction patterns.
    drive_cycle(1'b1, 4'b0101);
    wait_idle(4'b0101);
    drive_cycle(1'b1, 4'b1010);
    wait_idle(4'b1010);

    // Ignored triggers mid-packet, on the last busy edge and on the return
    // edge, then a back-to-back trigger one cycle after BUSY falls.
    drive_cycle(1'b1, 4'b0101);
    e0 = acc_edge;
    send_on_edge(e0 + 10, 4'b0101);
    send_on_edge(e0 + 79, 4'b0101);
    send_on_edge(e0 + 80, 4'b0101);
    send_on_edge(e0 + 81, 4'b1100);
    drive_cycle(1'b0, 4'b1100);
    check("busy_after_back_to_back", 32'(BUSY), 32'd1);
    wait_idle(4'b1100);

    // COMMAND changes during the start burst must not affect the packet.
    drive_cycle(1'b1, 4'b0101);
    e0 = acc_edge;
    while (cyc + 2 < e0 + 6) drive_cycle(1'b0, 4'b0101);
    drive_cycle(1'b0, 4'b1111);
    wait_idle(4'b1111);

    // Reset asserted mid-burst, between clock edges.
    drive_cycle(1'b1, 4'b0011);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive_cycle(1'b0, 4'b0011);
      if (IR_LED === 1'b1) found = 1'b1;
    end
    check("led_high_before_reset", 32'(found), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_led", 32'(IR_LED), 32'd0);
    check("async_reset_busy", 32'(BUSY), 32'd0);
    SEND = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N  = 1'b1;
    acc_edge = 0;
    end_edge = 0;
    drive_cycle(1'b1, 4'b0110);
    wait_idle(4'b0110);

    // Randomized triggers and command churn.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : COMMAND;
      drive_cycle($urandom_range(0, 19) == 0, c);
    end
    wait_idle(COMMAND);

    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && mon_mode == 0) break;
      @(negedge CLK);
    end
    check("scoreboard_drained", 32'(exp_q.size() + ((mon_mode != 0) ? 1 : 0)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
